// File: rtl/num_entry.sv
// num_entry: digit-by-digit decimal operand editor with serial BCD-to-binary conversion
// and a VALID/READY hand-off of the binary result.
module num_entry #(
  parameter int NDIG = 4,
  parameter int W    = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        bin_i,
  output logic [4*NDIG-1:0] dig_o,
  output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] cur_o,
  output logic              busy_o,
  output logic [W-1:0]      num_o,
  output logic              valid_o,
  input  logic              ready_i
);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {EDIT, CONV, HOLD} state_t;
  state_t                 state_q, state_d;
  logic [NDIG-1:0][3:0]   dig_q, dig_d;
  logic [CW-1:0]          cur_q, cur_d, idx_q, idx_d;
  logic [W-1:0]           acc_q, acc_d, num_q, num_d, acc_nx;
  logic                   valid_q, valid_d;
  assign acc_nx = (acc_q << 3) + (acc_q << 1) + W'(dig_q[idx_q]);
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    num_d   = num_q;
    valid_d = valid_q;
    case (state_q)
      EDIT: begin
        // one action per cycle, ENTER > INC > DEC > LEFT > RIGHT
        if (bin_i[4]) begin
          acc_d   = '0;
          idx_d   = CW'(NDIG - 1);
          state_d = CONV;
        end else if (bin_i[0])
          dig_d[cur_q] = (dig_q[cur_q] == 4'd9) ? 4'd0 : dig_q[cur_q] + 4'd1;
        else if (bin_i[1])
          dig_d[cur_q] = (dig_q[cur_q] == 4'd0) ? 4'd9 : dig_q[cur_q] - 4'd1;
        else if (bin_i[2])
          cur_d = (cur_q == CW'(NDIG - 1)) ? '0 : cur_q + CW'(1);
        else if (bin_i[3])
          cur_d = (cur_q == '0) ? CW'(NDIG - 1) : cur_q - CW'(1);
      end
      CONV: begin
        acc_d = acc_nx;
        idx_d = idx_q - CW'(1);
        if (idx_q == '0) begin
          num_d   = acc_nx;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EDIT;
      dig_q   <= '0;
      cur_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      valid_q <= valid_d;
    end
  end
  assign dig_o   = dig_q;
  assign cur_o   = cur_q;
  assign busy_o  = (state_q != EDIT);
  assign num_o   = num_q;
  assign valid_o = valid_q;
endmodule
